regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a built-in scoreboard for the pipelined NPC core. It provides NR_READ combinational read ports, one write port, per-register busy tracking for in-flight destinations, and an optional same-cycle write-to-read bypass. It sits between decode/issue, which reads operands and reserves rd, and writeback, which writes and releases rd. Register 0 is hardwired to zero and is never busy.

## Interface
- ADDR_WIDTH, 5: register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register data width.
- NR_READ, 2: number of read ports (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- raddr  in  NR_READ*ADDR_WIDTH  read indices, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rvalid  in  NR_READ  per-port operand valid; a low bit forces that port's outputs to zero.
- rdata  out  NR_READ*DATA_WIDTH  read data, packed the same way as raddr.
- rbusy  out  NR_READ  the operand's register has a pending write.
- wen  in  1  write enable.
- waddr  in  ADDR_WIDTH  write index.
- wdata  in  DATA_WIDTH  write data.
- iss_valid  in  1  issue request that reserves iss_rd.
- iss_rd  in  ADDR_WIDTH  destination register to reserve.
- iss_ready  out  1  the reservation can be accepted this cycle.
- busy_cnt  out  ADDR_WIDTH+1  number of registers currently busy.

## Operation
- Storage: `rf[0..2**ADDR_WIDTH-1]` and `busy[0..2**ADDR_WIDTH-1]`.
- Reset: while rst is high, all rf entries, all busy bits and busy_cnt are 0. Reset is asynchronous and takes effect mid-operation, with no edge needed.
- Write: on a clk edge with wen=1 and waddr≠0, `rf[waddr] <= wdata` and `busy[waddr] <= 0`. A write with waddr=0 is ignored.
- Issue:
  - `iss_ready = (iss_rd==0) | ~busy[iss_rd]`. The check is WAW-safe: a busy rd stalls issue.
  - On an edge with iss_valid & iss_ready & iss_rd≠0, `busy[iss_rd] <= 1`.
  - iss_rd=0 is always accepted and has no effect.
- Write and issue to the same register in the same cycle: the set wins, so busy stays 1 and rf takes wdata. This is legal when the register was already non-busy, e.g. a late write from a non-tracked source.
- Read port i, all combinational:
  - rvalid[i]=0 or raddr_i=0: rdata_i=0, rbusy[i]=0.
  - Otherwise: rdata_i = rf[raddr_i] and rbusy[i] = busy[raddr_i], subject to the bypass (see Configuration).
- busy_cnt is a registered count updated every edge: +1 on an accepted issue with rd≠0; −1 on a write that clears a set busy bit; net 0 when both occur. It never exceeds 2**ADDR_WIDTH−1.

## Timing
- Read: 0-cycle latency, combinational from raddr/rvalid, and from wen/waddr/wdata when the bypass is enabled.
- Write is visible to reads in the cycle after the edge (or in the same cycle with the bypass).
- A busy bit set by an issue is visible on rbusy/iss_ready the cycle after the accepting edge. A busy bit cleared by a write is visible the cycle after the write edge (or in the same cycle for rbusy with the bypass).
- iss_ready is combinational from iss_rd and busy. It does not depend on iss_valid.
- Reset values of outputs: rdata=0 (all entries are 0), rbusy=0, iss_ready=1, busy_cnt=0.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: if wen=1, waddr≠0 and waddr==raddr_i with rvalid[i]=1, then rdata_i=wdata and rbusy[i]=0 in the same cycle. Storage update timing is unchanged. iss_ready is not bypassed.
- Undefined: reads always return the stored rf value and the stored busy bit. A same-cycle write is seen the next cycle.

## Test plan
- Reset: assert rst mid-run after writing x5=0xDEADBEEF and issuing x7 → rdata(x5)=0, rbusy=0, busy_cnt=0, iss_ready=1 immediately, without a clock edge.
- x0: write x0=0x1234 and issue iss_rd=0 → raddr=0 reads 0, rbusy=0, busy_cnt unchanged, iss_ready=1.
- Scoreboard:
  - Issue x3 → next cycle rbusy=1 for x3, iss_ready=0 for iss_rd=3, busy_cnt=1.
  - Write x3=0x55 → next cycle rbusy=0, rdata=0x55, busy_cnt=0.
- Simultaneous: issue x4 while writing x4=0x99 (x4 not busy) → busy[x4]=1, rf[x4]=0x99, busy_cnt=1. Issue x6 and write busy x3 in one cycle → busy_cnt unchanged.
- Bypass:
  - x9 busy, then write x9=0xA5A5 with raddr port1=9.
  - With REGFILE_BYPASS_EN: rdata1=0xA5A5 and rbusy[1]=0 in the same cycle.
  - Without it: old value and rbusy=1 in that cycle, then 0xA5A5 and rbusy=0 the next cycle.
- Multi-port (NR_READ=3): ports read x1, x2, x1 with rvalid=3'b101 → port1 outputs 0/0, ports 0 and 2 return identical rf[x1].

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a per-register busy scoreboard.
// NR_READ combinational read ports, one write port and one issue
// (reservation) port. Register 0 reads as zero and is never busy.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write
// (wdata and a cleared busy bit) straight onto matching read ports.
//
// Issue handshake: a reservation of iss_rd happens on the rising clk edge
// where iss_valid && iss_ready. iss_ready is a pure function of iss_rd and
// the stored busy bits; it never looks at iss_valid. The requester may
// hold iss_valid high while iss_ready is low, and the reservation is then
// taken on the first edge where iss_ready is high.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR_READ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
  input  logic [NR_READ-1:0]            rvalid,
  output logic [NR_READ*DATA_WIDTH-1:0] rdata,
  output logic [NR_READ-1:0]            rbusy,
  input  logic                          wen,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          iss_valid,
  input  logic [ADDR_WIDTH-1:0]         iss_rd,
  output logic                          iss_ready,
  output logic [ADDR_WIDTH:0]           busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;

  logic wr_hit;    // write that actually updates storage
  logic iss_acc;   // accepted reservation of a real register
  logic wr_clear;  // write that releases a register that was busy

  assign wr_hit  = wen && (waddr != '0);
  assign iss_acc = iss_valid && iss_ready && (iss_rd != '0);
  // A write and an accepted issue to the same register cannot make
  // wr_clear true: the issue is only accepted when that register is idle.
  assign wr_clear = wr_hit && busy[waddr];

  // Issue is WAW-safe: a destination that is still in flight stalls.
  assign iss_ready = (iss_rd == '0) || !busy[iss_rd];

  // Storage, busy bits and busy count; the issue set is applied after the
  // write clear so a same-cycle set on the same register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_hit) begin
        rf[waddr]   <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (iss_acc) begin
        busy[iss_rd] <= 1'b1;
      end
      case ({iss_acc, wr_clear})
        2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
        2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  for (genvar g = 0; g < NR_READ; g++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  bsy;

    assign addr = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

    // Read port: zero for an invalid operand or x0, else stored (or bypassed) value.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (rvalid[g] && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (waddr == addr)) begin
          data = wdata;
          bsy  = 1'b0;
        end else begin
          data = rf[addr];
          bsy  = busy[addr];
        end
`else
        data = rf[addr];
        bsy  = busy[addr];
`endif
      end
    end

    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rbusy[g]                          = bsy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed-vector bench for regfile_sb, built with three
// read ports. Expected values are hand-computed constants. Expectations in
// test_bypass follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic               clk;
  logic               rst;
  logic [NR*AW-1:0]   raddr;
  logic [NR-1:0]      rvalid;
  logic [NR*DW-1:0]   rdata;
  logic [NR-1:0]      rbusy;
  logic               wen;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               iss_valid;
  logic [AW-1:0]      iss_rd;
  logic               iss_ready;
  logic [AW:0]        busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_sb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NR_READ   (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raddr    (raddr),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .busy_cnt (busy_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input int port, input logic [AW-1:0] a);
    raddr[port*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd_port(input int port);
    return rdata[port*DW +: DW];
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    tick();
    wen = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic do_issue(input logic [AW-1:0] a);
    iss_valid = 1'b1; iss_rd = a;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rvalid = '1;
    set_raddr(0, 5); set_raddr(1, 7); set_raddr(2, 31);
    iss_rd = 7;
    #2;
    checks++;
    if (rd_port(0) !== 32'h0) begin
      errors++; $display("FAIL reset_rdata0 got %h exp %h", rd_port(0), 32'h0);
    end
    checks++;
    if (rbusy !== 3'b000) begin
      errors++; $display("FAIL reset_rbusy got %b exp %b", rbusy, 3'b000);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("FAIL reset_busy_cnt got %0d exp %0d", busy_cnt, 0);
    end
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL reset_iss_ready got %b exp %b", iss_ready, 1'b1);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    wen = 1'b1; waddr = 0; wdata = 32'h1234;
    iss_valid = 1'b1; iss_rd = 0;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL x0_iss_ready got %b exp %b", iss_ready, 1'b1);
    end
    tick();
    wen = 1'b0; iss_valid = 1'b0;
    rvalid = 3'b001; set_raddr(0, 0);
    #1;
    checks++;
    if (rd_port(0) !== 32'h0 || rbusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_read got %h/%b exp %h/%b", rd_port(0), rbusy[0], 32'h0, 1'b0);
    end
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("FAIL x0_busy_cnt got %0d exp %0d", busy_cnt, 0);
    end
  endtask

  task automatic test_scoreboard();
    rvalid = 3'b001; set_raddr(0, 3);
    iss_valid = 1'b1; iss_rd = 3;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL sb_ready_before got %b exp %b", iss_ready, 1'b1);
    end
    tick();
    iss_valid = 1'b0;
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || iss_ready !== 1'b0 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL sb_issue_x3 got rbusy=%b ready=%b cnt=%0d exp 1 0 1",
               rbusy[0], iss_ready, busy_cnt);
    end
    do_write(3, 32'h55);
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || rd_port(0) !== 32'h55 || busy_cnt !== 6'd0 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_write_x3 got rbusy=%b data=%h cnt=%0d ready=%b exp 0 00000055 0 1",
               rbusy[0], rd_port(0), busy_cnt, iss_ready);
    end
  endtask

  task automatic test_simultaneous();
    // x4 idle: set and write in one cycle, set wins.
    wen = 1'b1; waddr = 4; wdata = 32'h99;
    iss_valid = 1'b1; iss_rd = 4;
    tick();
    wen = 1'b0; iss_valid = 1'b0;
    rvalid = 3'b001; set_raddr(0, 4);
    #1;
    checks++;
    if (rbusy[0] !== 1'b1 || rd_port(0) !== 32'h99 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL sim_x4 got rbusy=%b data=%h cnt=%0d exp 1 00000099 1",
               rbusy[0], rd_port(0), busy_cnt);
    end
    do_issue(3);
    #1;
    checks++;
    if (busy_cnt !== 6'd2) begin
      errors++; $display("FAIL sim_cnt_two got %0d exp %0d", busy_cnt, 2);
    end
    // Issue x6 while releasing busy x3: count stays at 2.
    wen = 1'b1; waddr = 3; wdata = 32'h33;
    iss_valid = 1'b1; iss_rd = 6;
    tick();
    wen = 1'b0; iss_valid = 1'b0;
    rvalid = 3'b011; set_raddr(0, 6); set_raddr(1, 3);
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rbusy[1:0] !== 2'b01 || rd_port(1) !== 32'h33) begin
      errors++;
      $display("FAIL sim_x6_x3 got cnt=%0d rbusy=%b data1=%h exp 2 01 00000033",
               busy_cnt, rbusy[1:0], rd_port(1));
    end
    do_write(4, 32'h44);
    do_write(6, 32'h66);
    #1;
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("FAIL sim_drain got %0d exp %0d", busy_cnt, 0);
    end
  endtask

  task automatic test_bypass();
    do_issue(9);
    rvalid = 3'b010; set_raddr(1, 9);
    iss_rd = 9;
    wen = 1'b1; waddr = 9; wdata = 32'hA5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++;
    if (rd_port(1) !== 32'hA5A5 || rbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL byp_same_cycle got %h/%b exp %h/%b", rd_port(1), rbusy[1], 32'hA5A5, 1'b0);
    end
`else
    checks++;
    if (rd_port(1) !== 32'h0 || rbusy[1] !== 1'b1) begin
      errors++;
      $display("FAIL byp_same_cycle got %h/%b exp %h/%b", rd_port(1), rbusy[1], 32'h0, 1'b1);
    end
`endif
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++; $display("FAIL byp_iss_ready got %b exp %b", iss_ready, 1'b0);
    end
    tick();
    wen = 1'b0; waddr = '0; wdata = '0;
    #1;
    checks++;
    if (rd_port(1) !== 32'hA5A5 || rbusy[1] !== 1'b0 || busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL byp_next_cycle got %h/%b cnt=%0d exp %h/%b 0",
               rd_port(1), rbusy[1], busy_cnt, 32'hA5A5, 1'b0);
    end
  endtask

  task automatic test_multiport();
    do_write(1, 32'hCAFEF00D);
    do_write(2, 32'h2222);
    set_raddr(0, 1); set_raddr(1, 2); set_raddr(2, 1);
    rvalid = 3'b101;
    #1;
    checks++;
    if (rd_port(1) !== 32'h0 || rbusy[1] !== 1'b0) begin
      errors++;
      $display("FAIL mp_port1_off got %h/%b exp %h/%b", rd_port(1), rbusy[1], 32'h0, 1'b0);
    end
    checks++;
    if (rd_port(0) !== 32'hCAFEF00D || rd_port(2) !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mp_x1_twice got %h %h exp %h", rd_port(0), rd_port(2), 32'hCAFEF00D);
    end
    do_issue(1);
    #1;
    checks++;
    if (rbusy !== 3'b101) begin
      errors++; $display("FAIL mp_rbusy got %b exp %b", rbusy, 3'b101);
    end
    rvalid = 3'b111;
    #1;
    checks++;
    if (rd_port(1) !== 32'h2222 || rbusy !== 3'b101) begin
      errors++;
      $display("FAIL mp_all_on got %h/%b exp %h/%b", rd_port(1), rbusy, 32'h2222, 3'b101);
    end
    do_write(1, 32'h11);
  endtask

  task automatic test_async_reset();
    do_write(5, 32'hDEADBEEF);
    do_issue(7);
    rvalid = 3'b011; set_raddr(0, 5); set_raddr(1, 7);
    iss_rd = 7;
    #1;
    checks++;
    if (rd_port(0) !== 32'hDEADBEEF || rbusy[1] !== 1'b1 || busy_cnt !== 6'd1 || iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_before got %h/%b cnt=%0d ready=%b exp deadbeef/1 1 0",
               rd_port(0), rbusy[1], busy_cnt, iss_ready);
    end
    // Mid-cycle reset, well away from any clock edge.
    rst = 1'b1;
    #1;
    checks++;
    if (rd_port(0) !== 32'h0 || rbusy !== 3'b000 || busy_cnt !== 6'd0 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_after got %h/%b cnt=%0d ready=%b exp 00000000/000 0 1",
               rd_port(0), rbusy, busy_cnt, iss_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; rvalid = '0;
    wen = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0;
    test_reset();
    test_x0();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_multiport();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
